// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/operand/result bundle for the bit-serial subtractor.
interface serial_subtractor_if #(parameter int WIDTH = 8);
   logic             start;
   logic [WIDTH-1:0] A, B;
   logic             Bin;
   logic             busy, done;
   logic [WIDTH-1:0] D;
   logic             Bout, V;
   modport master (output start, A, B, Bin, input busy, done, D, Bout, V);
   modport slave (input start, A, B, Bin, output busy, done, D, Bout, V);
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: D = A - B - Bin, one bit per clock LSB first, through a single
// full-subtractor cell and a borrow flip-flop, under a start/done handshake.
module serial_subtractor #(parameter int WIDTH = 8) (
   input  logic clk,
   input  logic rst_n,
   serial_subtractor_if.slave bus
);
   localparam int CW = $clog2(WIDTH) + 1;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t           state, state_nx;
   logic [WIDTH-1:0] a_sh, b_sh, part;
   logic [CW-1:0]    cnt;
   logic             br, a_msb, b_msb;
   logic             d, br_nx, last, accept;
   always_comb begin
      d      = a_sh[0] ^ b_sh[0] ^ br;
      br_nx  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
      last   = cnt == CW'(WIDTH - 1);
      accept = bus.start && state != RUN;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = (state == RUN) ? (last ? DONE : RUN) : (bus.start ? RUN : IDLE);
   end
   always_comb begin
      bus.busy = state == RUN;
      bus.done = state == DONE;
   end
   // Results load only on the final bit so partial sums never reach D.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh     <= '0;
         b_sh     <= '0;
         part     <= '0;
         br       <= 1'b0;
         cnt      <= '0;
         a_msb    <= 1'b0;
         b_msb    <= 1'b0;
         bus.D    <= '0;
         bus.Bout <= 1'b0;
         bus.V    <= 1'b0;
      end else if (accept) begin
         a_sh  <= bus.A;
         b_sh  <= bus.B;
         part  <= '0;
         br    <= bus.Bin;
         cnt   <= '0;
         a_msb <= bus.A[WIDTH-1];
         b_msb <= bus.B[WIDTH-1];
      end else if (state == RUN) begin
         a_sh <= a_sh >> 1;
         b_sh <= b_sh >> 1;
         part <= {d, part[WIDTH-1:1]};
         br   <= br_nx;
         cnt  <= cnt + 1'b1;
         if (last) begin
            bus.D    <= {d, part[WIDTH-1:1]};
            bus.Bout <= br_nx;
            bus.V    <= (a_msb ^ b_msb) & (d ^ a_msb);
         end
      end
   end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed vectors on an 8-bit instance plus an exhaustive
// sweep of a 4-bit instance.
module tb_serial_subtractor;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   serial_subtractor_if #(.WIDTH(8)) bus8();
   serial_subtractor_if #(.WIDTH(4)) bus4();
   serial_subtractor #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
   serial_subtractor #(.WIDTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask
   // Walks negedges until done, scrambling the operand inputs every cycle.
   task automatic wait_done8(output int k, output int bc);
      k = 0;
      bc = 0;
      while (!bus8.done && k < 40) begin
         if (bus8.busy) bc++;
         @(negedge clk);
         k++;
         bus8.A = 8'($urandom);
         bus8.B = 8'($urandom);
         bus8.Bin = 1'($urandom);
      end
   endtask
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                      input logic [7:0] ed, input logic eb, input logic ev, input string tag);
      int k, bc;
      @(negedge clk);
      bus8.start = 1'b1;
      bus8.A = a;
      bus8.B = b;
      bus8.Bin = bin;
      @(negedge clk);
      bus8.start = 1'b0;
      wait_done8(k, bc);
      chk({tag, ".latency"}, k, 8);
      chk({tag, ".busy_cycles"}, bc, 8);
      chk({tag, ".busy_in_done"}, bus8.busy, 0);
      chk({tag, ".D"}, bus8.D, ed);
      chk({tag, ".Bout"}, bus8.Bout, eb);
      chk({tag, ".V"}, bus8.V, ev);
      @(negedge clk);
      chk({tag, ".done_pulse"}, bus8.done, 0);
   endtask
   task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bin);
      int k;
      logic [4:0] r;
      logic ev;
      @(negedge clk);
      bus4.start = 1'b1;
      bus4.A = a;
      bus4.B = b;
      bus4.Bin = bin;
      @(negedge clk);
      bus4.start = 1'b0;
      k = 0;
      while (!bus4.done && k < 20) begin
         @(negedge clk);
         k++;
      end
      r = 5'((int'(a) - int'(b) - int'(bin)) & 31);
      ev = (a[3] ^ b[3]) & (r[3] ^ a[3]);
      chk("w4.latency", k, 4);
      chk("w4.diff", {bus4.Bout, bus4.D}, r);
      chk("w4.V", bus4.V, ev);
   endtask
   initial begin
      int k, bc;
      bus8.start = 1'b0;
      bus8.A = '0;
      bus8.B = '0;
      bus8.Bin = 1'b0;
      bus4.start = 1'b0;
      bus4.A = '0;
      bus4.B = '0;
      bus4.Bin = 1'b0;
      #1;
      chk("rst.busy", bus8.busy, 0);
      chk("rst.done", bus8.done, 0);
      chk("rst.D", bus8.D, 0);
      chk("rst.Bout", bus8.Bout, 0);
      chk("rst.V", bus8.V, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      op8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, "v05m03");
      op8(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, "v03m05");
      op8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, "v00m00b");
      op8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, "v80m01");
      op8(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, "v7FmFF");
      // Start held high throughout; operands churn every cycle after acceptance.
      @(negedge clk);
      bus8.start = 1'b1;
      bus8.A = 8'h5A;
      bus8.B = 8'h3C;
      bus8.Bin = 1'b1;
      @(negedge clk);
      wait_done8(k, bc);
      chk("hold1.latency", k, 8);
      chk("hold1.D", bus8.D, 8'h1D);
      chk("hold1.Bout", bus8.Bout, 0);
      chk("hold1.V", bus8.V, 0);
      bus8.A = 8'h20;
      bus8.B = 8'hA0;
      bus8.Bin = 1'b0;
      @(negedge clk);
      wait_done8(k, bc);
      chk("hold2.gap", k + 1, 9);
      chk("hold2.D", bus8.D, 8'h80);
      chk("hold2.Bout", bus8.Bout, 1);
      chk("hold2.V", bus8.V, 1);
      bus8.start = 1'b0;
      @(negedge clk);
      chk("hold2.done_pulse", bus8.done, 0);
      // Asynchronous abort in the fourth RUN cycle.
      bus8.start = 1'b1;
      bus8.A = 8'h33;
      bus8.B = 8'h11;
      bus8.Bin = 1'b0;
      @(negedge clk);
      bus8.start = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort.busy_before", bus8.busy, 1);
      rst_n = 1'b0;
      #1;
      chk("abort.busy", bus8.busy, 0);
      chk("abort.done", bus8.done, 0);
      chk("abort.D", bus8.D, 0);
      chk("abort.Bout", bus8.Bout, 0);
      chk("abort.V", bus8.V, 0);
      @(negedge clk);
      rst_n = 1'b1;
      op8(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, "v10m01");
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            for (int c = 0; c < 2; c++)
               op4(4'(a), 4'(b), 1'(c));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
